// File: rtl/lsu_ctrl_pkg.sv
// Shared widths, access-size and FSM encodings for the load/store controller.
// Also holds the misalignment predicate used when LSU_MISALIGN_CHK_EN is defined.
package lsu_ctrl_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ADDR_SIZE = 32;

    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StRsp  = 2'd2;
    localparam logic [1:0] StWbck = 2'd3;

    // Size 3 is treated as a word access.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            LSU_SIZE_B: return 1'b0;
            LSU_SIZE_H: return lo[0];
            default:    return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Load-data aligner: shifts the read word down to the addressed lane, then
// truncates to the access size and sign- or zero-extends.
module lsu_ld_align
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned Xlen = 32
) (
    input  logic [Xlen-1:0] rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [1:0]      size_i,
    input  logic            usign_i,
    output logic [Xlen-1:0] result_o
);

    logic [Xlen-1:0] shifted;

    assign shifted = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        result_o = shifted;
        case (size_i)
            LSU_SIZE_B: result_o = {{(Xlen-8){~usign_i & shifted[7]}}, shifted[7:0]};
            LSU_SIZE_H: result_o = {{(Xlen-16){~usign_i & shifted[15]}}, shifted[15:0]};
            default:    result_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller: AGU command -> data-memory bus -> write-back.
// Define LSU_MISALIGN_CHK_EN to fault misaligned half/word accesses without a bus command.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned XLEN      = lsu_ctrl_pkg::XLEN,
    parameter int unsigned ADDR_SIZE = lsu_ctrl_pkg::ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 agu_icb_cmd_valid,
    output logic                 agu_icb_cmd_ready,
    input  logic [ADDR_SIZE-1:0] agu_icb_cmd_addr,
    input  logic                 agu_icb_cmd_read,
    input  logic [XLEN-1:0]      agu_icb_cmd_wdata,
    input  logic [XLEN/8-1:0]    agu_icb_cmd_wmask,
    input  logic [1:0]           agu_icb_cmd_size,
    input  logic                 agu_icb_cmd_usign,
    output logic                 mem_cmd_valid,
    input  logic                 mem_cmd_ready,
    output logic [ADDR_SIZE-1:0] mem_cmd_addr,
    output logic                 mem_cmd_read,
    output logic [XLEN-1:0]      mem_cmd_wdata,
    output logic [XLEN/8-1:0]    mem_cmd_wmask,
    input  logic                 mem_rsp_valid,
    output logic                 mem_rsp_ready,
    input  logic [XLEN-1:0]      mem_rsp_rdata,
    input  logic                 mem_rsp_err,
    output logic                 lsu_o_valid,
    input  logic                 lsu_o_ready,
    output logic [XLEN-1:0]      lsu_o_wbck_wdat,
    output logic                 lsu_o_cmt_ld,
    output logic                 lsu_o_cmt_st,
    output logic [ADDR_SIZE-1:0] lsu_o_excp_addr
);

    logic [1:0]           state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic                 read_q, read_d;
    logic [XLEN-1:0]      wdata_q, wdata_d;
    logic [XLEN/8-1:0]    wmask_q, wmask_d;
    logic [1:0]           size_q, size_d;
    logic                 usign_q, usign_d;
    logic [XLEN-1:0]      res_q, res_d;
    logic                 err_q, err_d;
    logic [XLEN-1:0]      ld_result;

    lsu_ld_align #(
        .Xlen(XLEN)
    ) u_ld_align (
        .rdata_i  (mem_rsp_rdata),
        .addr_lo_i(addr_q[1:0]),
        .size_i   (size_q),
        .usign_i  (usign_q),
        .result_o (ld_result)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        read_d  = read_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        size_d  = size_q;
        usign_d = usign_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (agu_icb_cmd_valid) begin
                    addr_d  = agu_icb_cmd_addr;
                    read_d  = agu_icb_cmd_read;
                    wdata_d = agu_icb_cmd_wdata;
                    wmask_d = agu_icb_cmd_wmask;
                    size_d  = agu_icb_cmd_size;
                    usign_d = agu_icb_cmd_usign;
`ifdef LSU_MISALIGN_CHK_EN
                    if (lsu_misaligned(agu_icb_cmd_size, agu_icb_cmd_addr[1:0])) begin
                        state_d = StWbck;
                        res_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StReq;
                    end
`else
                    state_d = StReq;
`endif
                end
            end
            StReq: begin
                if (mem_cmd_ready) state_d = StRsp;
            end
            StRsp: begin
                if (mem_rsp_valid) begin
                    state_d = StWbck;
                    res_d   = read_q ? ld_result : '0;
                    err_d   = mem_rsp_err;
                end
            end
            StWbck: begin
                if (lsu_o_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            read_q  <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            size_q  <= 2'b00;
            usign_q <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            size_q  <= size_d;
            usign_q <= usign_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // Ready drops with rst itself so no command is taken while reset is held.
    assign agu_icb_cmd_ready = (state_q == StIdle) && !rst;

    assign mem_cmd_valid   = (state_q == StReq);
    assign mem_cmd_addr    = {addr_q[ADDR_SIZE-1:2], 2'b00};
    assign mem_cmd_read    = read_q;
    assign mem_cmd_wdata   = wdata_q;
    assign mem_cmd_wmask   = wmask_q;
    assign mem_rsp_ready   = (state_q == StRsp);

    assign lsu_o_valid     = (state_q == StWbck);
    assign lsu_o_wbck_wdat = lsu_o_valid ? res_q : '0;
    assign lsu_o_cmt_ld    = lsu_o_valid & err_q & read_q;
    assign lsu_o_cmt_st    = lsu_o_valid & err_q & ~read_q;
    assign lsu_o_excp_addr = addr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: vector table driven through a cycle-exact bus model,
// with a write-back scoreboard plus hand-written reset and stall sequences.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        agu_icb_cmd_valid;
    logic        agu_icb_cmd_ready;
    logic [31:0] agu_icb_cmd_addr;
    logic        agu_icb_cmd_read;
    logic [31:0] agu_icb_cmd_wdata;
    logic [3:0]  agu_icb_cmd_wmask;
    logic [1:0]  agu_icb_cmd_size;
    logic        agu_icb_cmd_usign;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic [31:0] mem_cmd_addr;
    logic        mem_cmd_read;
    logic [31:0] mem_cmd_wdata;
    logic [3:0]  mem_cmd_wmask;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_rdata;
    logic        mem_rsp_err;
    logic        lsu_o_valid;
    logic        lsu_o_ready;
    logic [31:0] lsu_o_wbck_wdat;
    logic        lsu_o_cmt_ld;
    logic        lsu_o_cmt_st;
    logic [31:0] lsu_o_excp_addr;

    lsu_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .agu_icb_cmd_valid(agu_icb_cmd_valid),
        .agu_icb_cmd_ready(agu_icb_cmd_ready),
        .agu_icb_cmd_addr (agu_icb_cmd_addr),
        .agu_icb_cmd_read (agu_icb_cmd_read),
        .agu_icb_cmd_wdata(agu_icb_cmd_wdata),
        .agu_icb_cmd_wmask(agu_icb_cmd_wmask),
        .agu_icb_cmd_size (agu_icb_cmd_size),
        .agu_icb_cmd_usign(agu_icb_cmd_usign),
        .mem_cmd_valid    (mem_cmd_valid),
        .mem_cmd_ready    (mem_cmd_ready),
        .mem_cmd_addr     (mem_cmd_addr),
        .mem_cmd_read     (mem_cmd_read),
        .mem_cmd_wdata    (mem_cmd_wdata),
        .mem_cmd_wmask    (mem_cmd_wmask),
        .mem_rsp_valid    (mem_rsp_valid),
        .mem_rsp_ready    (mem_rsp_ready),
        .mem_rsp_rdata    (mem_rsp_rdata),
        .mem_rsp_err      (mem_rsp_err),
        .lsu_o_valid      (lsu_o_valid),
        .lsu_o_ready      (lsu_o_ready),
        .lsu_o_wbck_wdat  (lsu_o_wbck_wdat),
        .lsu_o_cmt_ld     (lsu_o_cmt_ld),
        .lsu_o_cmt_st     (lsu_o_cmt_st),
        .lsu_o_excp_addr  (lsu_o_excp_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        read;
        logic [1:0]  size;
        logic        usign;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        logic        err;
        int          cmd_stall;
        int          wb_stall;
        logic [31:0] exp_wdat;
    } vec_t;

    typedef struct {
        logic [31:0] wdat;
        logic [31:0] excp;
        logic        ld;
        logic        st;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    function automatic vec_t mkv(input string n, input logic [31:0] addr, input logic read,
                                 input logic [1:0] size, input logic usign,
                                 input logic [31:0] wdata, input logic [3:0] wmask,
                                 input logic [31:0] rdata, input logic err, input int cs,
                                 input int ws, input logic [31:0] exp_wdat);
        vec_t v;
        v.name = n; v.addr = addr; v.read = read; v.size = size; v.usign = usign;
        v.wdata = wdata; v.wmask = wmask; v.rdata = rdata; v.err = err;
        v.cmd_stall = cs; v.wb_stall = ws; v.exp_wdat = exp_wdat;
        return v;
    endfunction

    function automatic logic tb_mis(input logic [1:0] size, input logic [31:0] addr);
        logic m;
        m = 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
        if (size == 2'd1) m = addr[0];
        else if (size != 2'd0) m = (addr[1:0] != 2'b00);
`endif
        return m;
    endfunction

    // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 back in IDLE.
    task automatic run_vec(input vec_t v);
        exp_t e, got;
        logic mis;
        mis    = tb_mis(v.size, v.addr);
        e.wdat = (v.read && !mis) ? v.exp_wdat : 32'h0;
        e.excp = v.addr;
        e.ld   = (v.err || mis) && v.read;
        e.st   = (v.err || mis) && !v.read;
        chk({v.name, " agu_ready"}, agu_icb_cmd_ready, 1);
        agu_icb_cmd_valid = 1'b1;
        agu_icb_cmd_addr  = v.addr;
        agu_icb_cmd_read  = v.read;
        agu_icb_cmd_wdata = v.wdata;
        agu_icb_cmd_wmask = v.wmask;
        agu_icb_cmd_size  = v.size;
        agu_icb_cmd_usign = v.usign;
        sb.push_back(e);
        @(posedge clk); #1;
        agu_icb_cmd_valid = 1'b0;
        agu_icb_cmd_addr  = $urandom;
        agu_icb_cmd_wdata = $urandom;
        if (!mis) begin
            for (int i = 0; i <= v.cmd_stall; i++) begin
                chk({v.name, " cmd_valid"}, mem_cmd_valid, 1);
                chk({v.name, " cmd_addr"}, mem_cmd_addr, {v.addr[31:2], 2'b00});
                chk({v.name, " cmd_read"}, mem_cmd_read, v.read);
                chk({v.name, " cmd_wdata"}, mem_cmd_wdata, v.wdata);
                chk({v.name, " cmd_wmask"}, mem_cmd_wmask, v.wmask);
                chk({v.name, " early_valid"}, lsu_o_valid, 0);
                mem_cmd_ready = (i == v.cmd_stall);
                @(posedge clk); #1;
            end
            mem_cmd_ready = 1'b0;
            chk({v.name, " cmd_dropped"}, mem_cmd_valid, 0);
            chk({v.name, " rsp_ready"}, mem_rsp_ready, 1);
            chk({v.name, " early_valid"}, lsu_o_valid, 0);
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = v.rdata;
            mem_rsp_err   = v.err;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = $urandom;
            mem_rsp_err   = 1'b0;
        end else begin
            chk({v.name, " no_cmd"}, mem_cmd_valid, 0);
        end
        for (int w = 0; w <= v.wb_stall; w++) begin
            chk({v.name, " wb_valid"}, lsu_o_valid, 1);
            chk({v.name, " agu_blocked"}, agu_icb_cmd_ready, 0);
            chk({v.name, " rsp_closed"}, mem_rsp_ready, 0);
            lsu_o_ready = (w == v.wb_stall);
            if (w == v.wb_stall) begin
                if (sb.size() == 0) begin
                    chk({v.name, " sb_empty"}, 1, 0);
                end else begin
                    got = sb.pop_front();
                    chk({v.name, " wdat"}, lsu_o_wbck_wdat, got.wdat);
                    chk({v.name, " cmt_ld"}, lsu_o_cmt_ld, got.ld);
                    chk({v.name, " cmt_st"}, lsu_o_cmt_st, got.st);
                    chk({v.name, " excp_addr"}, lsu_o_excp_addr, got.excp);
                end
            end else begin
                chk({v.name, " hold_wdat"}, lsu_o_wbck_wdat, e.wdat);
                chk({v.name, " hold_cmt_ld"}, lsu_o_cmt_ld, e.ld);
            end
            @(posedge clk); #1;
        end
        lsu_o_ready = 1'b0;
        chk({v.name, " back_idle"}, lsu_o_valid, 0);
        chk({v.name, " agu_ready_again"}, agu_icb_cmd_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        agu_icb_cmd_valid = 1'b0; agu_icb_cmd_addr = '0; agu_icb_cmd_read = 1'b0;
        agu_icb_cmd_wdata = '0; agu_icb_cmd_wmask = '0; agu_icb_cmd_size = '0;
        agu_icb_cmd_usign = 1'b0; mem_cmd_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0; mem_rsp_err = 1'b0; lsu_o_ready = 1'b0;

        vecs.push_back(mkv("ld_word", 32'h8000_0004, 1, 2, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0,
                           32'hDEAD_BEEF));
        vecs.push_back(mkv("ld_byte_s", 32'h103, 1, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 0,
                           32'hFFFF_FF80));
        vecs.push_back(mkv("ld_byte_u", 32'h103, 1, 0, 1, 0, 0, 32'h8000_0000, 0, 0, 0,
                           32'h0000_0080));
        vecs.push_back(mkv("st_stall", 32'h200, 0, 2, 0, 32'h1234_5678, 4'hF, 32'hA5A5_A5A5,
                           0, 4, 0, 32'h0));
        vecs.push_back(mkv("ld_err", 32'h40, 1, 2, 0, 0, 0, 32'h1122_3344, 1, 0, 2,
                           32'h1122_3344));
        vecs.push_back(mkv("ld_half_s", 32'h102, 1, 1, 0, 0, 0, 32'h8001_1234, 0, 1, 0,
                           32'hFFFF_8001));
        vecs.push_back(mkv("ld_half_u", 32'h102, 1, 1, 1, 0, 0, 32'h8001_1234, 0, 0, 1,
                           32'h0000_8001));
        vecs.push_back(mkv("st_err", 32'h300, 0, 0, 0, 32'hFF, 4'h1, 32'h0, 1, 0, 0, 32'h0));
        vecs.push_back(mkv("ld_byte_pos", 32'h101, 1, 0, 0, 0, 0, 32'h0000_7F00, 0, 0, 0,
                           32'h0000_007F));
        vecs.push_back(mkv("ld_size3", 32'h10, 1, 3, 0, 0, 0, 32'h8765_4321, 0, 0, 0,
                           32'h8765_4321));
        vecs.push_back(mkv("ld_word_off1", 32'h1, 1, 2, 0, 0, 0, 32'hAABB_CCDD, 0, 0, 0,
                           32'h00AA_BBCC));
        vecs.push_back(mkv("st_half_mis", 32'h101, 0, 1, 0, 32'h0000_BE00, 4'h6, 32'h0, 0, 0,
                           0, 32'h0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst agu_ready", agu_icb_cmd_ready, 0);
        chk("rst cmd_valid", mem_cmd_valid, 0);
        chk("rst rsp_ready", mem_rsp_ready, 0);
        chk("rst lsu_valid", lsu_o_valid, 0);
        chk("rst excp_addr", lsu_o_excp_addr, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst agu_ready", agu_icb_cmd_ready, 1);

        for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k]);

        // Reset while waiting for a response; the late response must be ignored.
        agu_icb_cmd_valid = 1'b1; agu_icb_cmd_addr = 32'h500; agu_icb_cmd_read = 1'b1;
        agu_icb_cmd_size = 2'd2; agu_icb_cmd_usign = 1'b0;
        @(posedge clk); #1;
        agu_icb_cmd_valid = 1'b0;
        mem_cmd_ready = 1'b1;
        @(posedge clk); #1;
        mem_cmd_ready = 1'b0;
        chk("midrst in_rsp", mem_rsp_ready, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst rsp_ready", mem_rsp_ready, 0);
        chk("midrst agu_ready", agu_icb_cmd_ready, 0);
        chk("midrst cmd_addr", mem_cmd_addr, 0);
        chk("midrst excp_addr", lsu_o_excp_addr, 0);
        chk("midrst lsu_valid", lsu_o_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hFFFF_FFFF;
        #1;
        chk("midrst idle_ready", agu_icb_cmd_ready, 1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("late_rsp lsu_valid", lsu_o_valid, 0);
            chk("late_rsp rsp_ready", mem_rsp_ready, 0);
        end
        mem_rsp_valid = 1'b0;
        @(posedge clk); #1;
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
